br_predict_ctrl: RTL and testbench

- Parametrised successor to the pipeline's branch/PC-select control.
- Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters. Fetch uses it for taken/not-taken prediction.
- At resolve it compares the actual outcome against the carried prediction and drives a registered PC-mux select plus a pipeline flush.
- Sits between fetch (prediction) and the execute/mem resolve stage (redirect).

---
 rtl/br_predict_ctrl_if.sv | 48 ++++
 rtl/br_predict_ctrl.sv | 171 +++++++++++++++++
 tb/tb_br_predict_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/br_predict_ctrl_if.sv
// ---------------------------------------------------------------------------
// br_predict_ctrl_if
// Bundles the fetch-side prediction port and the resolve-side redirect port
// of the branch prediction / PC-select controller.
//
// Parameters:
//   ADDR_W              PC width
//
// Signals:
//   fetch_pc            PC of the instruction being fetched
//   predict_taken       taken/not-taken prediction for fetch_pc
//   resolve_valid       a resolving instruction is present this cycle
//   resolve_pc          PC of the resolving instruction
//   resolve_opcode      LC-3b opcode of the resolving instruction
//   branch_enable       actual BR condition outcome (nzp match)
//   resolve_pred_taken  prediction fetch made for the resolving instruction
//   pcmux_sel           registered PC redirect select
//   flush               registered squash of younger instructions
//
// Modports:
//   master  pipeline side (drives fetch/resolve, receives prediction/redirect)
//   slave   controller side
// ---------------------------------------------------------------------------
interface br_predict_ctrl_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] fetch_pc;
   logic              predict_taken;
   logic              resolve_valid;
   logic [ADDR_W-1:0] resolve_pc;
   logic [3:0]        resolve_opcode;
   logic              branch_enable;
   logic              resolve_pred_taken;
   logic [1:0]        pcmux_sel;
   logic              flush;

   modport master (
      output fetch_pc, resolve_valid, resolve_pc, resolve_opcode,
             branch_enable, resolve_pred_taken,
      input  predict_taken, pcmux_sel, flush
   );

   modport slave (
      input  fetch_pc, resolve_valid, resolve_pc, resolve_opcode,
             branch_enable, resolve_pred_taken,
      output predict_taken, pcmux_sel, flush
   );
endinterface

// File: rtl/br_predict_ctrl.sv
// ---------------------------------------------------------------------------
// br_predict_ctrl
// Branch prediction and PC-select control. A direct-mapped table of 2-bit
// saturating counters, indexed by pc[IDX_W:1], gives fetch a taken/not-taken
// prediction. At resolve the actual outcome is compared with the carried
// prediction and a registered PC-mux select plus flush are produced.
//
// Parameters:
//   ADDR_W    PC width
//   IDX_W     table index bits (2**IDX_W entries), 1..ADDR_W-1
//   CTR_INIT  counter reset value
//
// Ports:
//   clk               clock
//   rst               asynchronous active-high reset
//   bus               br_predict_ctrl_if.slave (fetch + resolve signals)
//   stat_branches     resolved BR count     (BR_PREDICT_STATS_EN only)
//   stat_mispredicts  mispredicted BR count (BR_PREDICT_STATS_EN only)
//
// Optional feature macro: BR_PREDICT_STATS_EN adds the two statistics
// counters. Without it the block is complete and the ports do not exist.
// ---------------------------------------------------------------------------
module br_predict_ctrl #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned IDX_W    = 4,
   parameter logic [1:0]  CTR_INIT = 2'b01
) (
   input  logic               clk,
   input  logic               rst,
   br_predict_ctrl_if.slave   bus
`ifdef BR_PREDICT_STATS_EN
   ,
   output logic [31:0]        stat_branches,
   output logic [31:0]        stat_mispredicts
`endif
);

   localparam int unsigned NUM_ENT = 1 << IDX_W;

   typedef enum logic [3:0] {
      OP_BR   = 4'h0, OP_ADD  = 4'h1, OP_LDB  = 4'h2, OP_STB  = 4'h3,
      OP_JSR  = 4'h4, OP_AND  = 4'h5, OP_LDW  = 4'h6, OP_STW  = 4'h7,
      OP_RTI  = 4'h8, OP_NOT  = 4'h9, OP_LDI  = 4'hA, OP_STI  = 4'hB,
      OP_JMP  = 4'hC, OP_SHF  = 4'hD, OP_LEA  = 4'hE, OP_TRAP = 4'hF
   } lc3b_opcode_e;

   typedef enum logic [1:0] {
      PC_SEQ      = 2'b00,
      PC_TARGET   = 2'b01,
      PC_TRAP     = 2'b10,
      PC_FALLTHRU = 2'b11
   } pcmux_sel_e;

   logic [1:0]   bht_q [NUM_ENT];
   logic [1:0]   bht_d [NUM_ENT];
   pcmux_sel_e   pcmux_sel_q, pcmux_sel_d;
   logic         flush_q, flush_d;

   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] resolve_idx;
   lc3b_opcode_e     opcode;
   logic             is_br;
   logic             mispredict;

   // Bit 0 of each PC is never used (word-aligned instructions) nor are the
   // bits above the index; aliasing PCs deliberately share one counter.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.fetch_pc, bus.resolve_pc};

   assign fetch_idx   = bus.fetch_pc[IDX_W:1];
   assign resolve_idx = bus.resolve_pc[IDX_W:1];
   assign opcode      = lc3b_opcode_e'(bus.resolve_opcode);
   assign is_br       = bus.resolve_valid && (opcode == OP_BR);
   assign mispredict  = bus.branch_enable != bus.resolve_pred_taken;

   // Read from current state with no bypass: a same-cycle update to the same
   // entry is only visible from the next cycle on.
   assign bus.predict_taken = bht_q[fetch_idx][1];
   assign bus.pcmux_sel     = pcmux_sel_q;
   assign bus.flush         = flush_q;

   // NOTE: every combinational output gets a default before any branch so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      pcmux_sel_d = PC_SEQ;
      flush_d     = 1'b0;
      bht_d       = bht_q;

      if (bus.resolve_valid) begin
         case (opcode)
            OP_BR: begin
               if (bus.branch_enable && !bus.resolve_pred_taken) begin
                  pcmux_sel_d = PC_TARGET;
                  flush_d     = 1'b1;
               end else if (!bus.branch_enable && bus.resolve_pred_taken) begin
                  pcmux_sel_d = PC_FALLTHRU;
                  flush_d     = 1'b1;
               end
            end
            OP_JMP, OP_JSR: begin
               pcmux_sel_d = PC_TARGET;
               flush_d     = 1'b1;
            end
            OP_TRAP: begin
               pcmux_sel_d = PC_TRAP;
               flush_d     = 1'b1;
            end
            default: ;
         endcase
      end

      // Saturating update: the end values are held, never wrapped.
      if (is_br) begin
         if (bus.branch_enable) begin
            if (bht_q[resolve_idx] != 2'b11)
               bht_d[resolve_idx] = bht_q[resolve_idx] + 2'd1;
         end else begin
            if (bht_q[resolve_idx] != 2'b00)
               bht_d[resolve_idx] = bht_q[resolve_idx] - 2'd1;
         end
      end
   end

   // NOTE: the counter table is reset like ordinary flops (not left to a RAM
   // macro) because every entry must read CTR_INIT straight out of reset.
   // NOTE: sequential state uses non-blocking assignment so all registers
   // sample pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENT; i++) bht_q[i] <= CTR_INIT;
         pcmux_sel_q <= PC_SEQ;
         flush_q     <= 1'b0;
      end else begin
         bht_q       <= bht_d;
         pcmux_sel_q <= pcmux_sel_d;
         flush_q     <= flush_d;
      end
   end

`ifdef BR_PREDICT_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

   // Both counters wrap modulo 2**32 by natural overflow.
   always_comb begin
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (is_br) begin
         stat_branches_d = stat_branches_q + 32'd1;
         if (mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`else
   logic unused_mispredict;
   assign unused_mispredict = mispredict;
`endif

endmodule

// File: tb/tb_br_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_br_predict_ctrl
// Directed bench for br_predict_ctrl. A behavioural model (integer counters
// clamped to 0..3, opcode-level redirect rules) tracks the expected state;
// one compare process checks every output each negedge, and hand-computed
// literals at key points pin the model itself.
// Optional: define BR_PREDICT_STATS_EN to also check the statistics ports.
// ---------------------------------------------------------------------------
module tb_br_predict_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   br_predict_ctrl_if #(.ADDR_W(16)) bus ();

`ifdef BR_PREDICT_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   br_predict_ctrl #(
      .ADDR_W   (16),
      .IDX_W    (4),
      .CTR_INIT (2'b01)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef BR_PREDICT_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_ctr [16];
   int exp_sel;
   int exp_flush;
   int m_branches;
   int m_mispredicts;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) m_ctr[i] = 1;
         exp_sel = 0;
         exp_flush = 0;
         m_branches = 0;
         m_mispredicts = 0;
      end else begin
         int idx;
         exp_sel = 0;
         exp_flush = 0;
         idx = (int'(bus.resolve_pc) / 2) % 16;
         if (bus.resolve_valid) begin
            case (int'(bus.resolve_opcode))
               0: begin
                  m_branches++;
                  if (bus.branch_enable != bus.resolve_pred_taken) begin
                     m_mispredicts++;
                     exp_flush = 1;
                     exp_sel = bus.branch_enable ? 1 : 3;
                  end
                  if (bus.branch_enable) m_ctr[idx] = (m_ctr[idx] >= 3) ? 3 : m_ctr[idx] + 1;
                  else                   m_ctr[idx] = (m_ctr[idx] <= 0) ? 0 : m_ctr[idx] - 1;
               end
               4, 12: begin exp_sel = 1; exp_flush = 1; end
               15:    begin exp_sel = 2; exp_flush = 1; end
               default: ;
            endcase
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         int fidx;
         fidx = (int'(bus.fetch_pc) / 2) % 16;
         check("predict_taken", 32'(bus.predict_taken), 32'(m_ctr[fidx] >= 2));
         check("pcmux_sel", 32'(bus.pcmux_sel), 32'(exp_sel));
         check("flush", 32'(bus.flush), 32'(exp_flush));
`ifdef BR_PREDICT_STATS_EN
         check("stat_branches", stat_branches, 32'(m_branches));
         check("stat_mispredicts", stat_mispredicts, 32'(m_mispredicts));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [15:0] fpc, input logic v, input logic [15:0] rpc,
                        input logic [3:0] op, input logic be, input logic pred);
      @(posedge clk);
      #1;
      bus.fetch_pc           = fpc;
      bus.resolve_valid      = v;
      bus.resolve_pc         = rpc;
      bus.resolve_opcode     = op;
      bus.branch_enable      = be;
      bus.resolve_pred_taken = pred;
   endtask

   task automatic idle(input logic [15:0] fpc);
      drive(fpc, 1'b0, 16'h0000, 4'h1, 1'b0, 1'b0);
   endtask

   task automatic mid_cycle;
      @(negedge clk);
      #1;
   endtask

   initial begin
      bus.fetch_pc           = 16'h3000;
      bus.resolve_valid      = 1'b0;
      bus.resolve_pc         = 16'h0000;
      bus.resolve_opcode     = 4'h1;
      bus.branch_enable      = 1'b0;
      bus.resolve_pred_taken = 1'b0;

      // Reset state
      #12;
      check("rst_predict_taken", 32'(bus.predict_taken), 32'd0);
      check("rst_pcmux_sel", 32'(bus.pcmux_sel), 32'd0);
      check("rst_flush", 32'(bus.flush), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;

      // Sweep every entry: all weakly not-taken
      for (int i = 0; i < 16; i++) idle(16'(i * 2));

      // Three taken BRs predicted not-taken at 0x3004 (idx 2): 01->10->11->11
      drive(16'h3004, 1'b1, 16'h3004, 4'h0, 1'b1, 1'b0);
      drive(16'h3004, 1'b1, 16'h3004, 4'h0, 1'b1, 1'b0);
      mid_cycle();
      check("first_update_pt", 32'(bus.predict_taken), 32'd1);
      check("br_taken_sel", 32'(bus.pcmux_sel), 32'd1);
      check("br_taken_flush", 32'(bus.flush), 32'd1);
      drive(16'h3004, 1'b1, 16'h3004, 4'h0, 1'b1, 1'b0);
      idle(16'h3004);
      mid_cycle();
      check("model_idx2_sat_hi", 32'(m_ctr[2]), 32'd3);

      // Four not-taken BRs predicted taken: 11->10->01->00->00
      drive(16'h3004, 1'b1, 16'h3004, 4'h0, 1'b0, 1'b1);
      drive(16'h3004, 1'b1, 16'h3004, 4'h0, 1'b0, 1'b1);
      mid_cycle();
      check("br_nt_sel", 32'(bus.pcmux_sel), 32'd3);
      check("br_nt_flush", 32'(bus.flush), 32'd1);
      check("after_one_dec_pt", 32'(bus.predict_taken), 32'd1);
      drive(16'h3004, 1'b1, 16'h3004, 4'h0, 1'b0, 1'b1);
      drive(16'h3004, 1'b1, 16'h3004, 4'h0, 1'b0, 1'b1);
      idle(16'h3004);
      mid_cycle();
      check("model_idx2_sat_lo", 32'(m_ctr[2]), 32'd0);
      check("sat_lo_pt", 32'(bus.predict_taken), 32'd0);

      // TRAP / JMP / JSR / ADD / invalid BR
      drive(16'h3004, 1'b1, 16'h3004, 4'hF, 1'b1, 1'b0);
      drive(16'h3004, 1'b1, 16'h3004, 4'hC, 1'b1, 1'b0);
      mid_cycle();
      check("trap_sel", 32'(bus.pcmux_sel), 32'd2);
      check("trap_flush", 32'(bus.flush), 32'd1);
      drive(16'h3004, 1'b1, 16'h3004, 4'h4, 1'b1, 1'b0);
      mid_cycle();
      check("jmp_sel", 32'(bus.pcmux_sel), 32'd1);
      drive(16'h3004, 1'b1, 16'h3004, 4'h1, 1'b1, 1'b0);
      mid_cycle();
      check("jsr_sel", 32'(bus.pcmux_sel), 32'd1);
      check("jsr_flush", 32'(bus.flush), 32'd1);
      drive(16'h3004, 1'b0, 16'h3004, 4'h0, 1'b1, 1'b0);
      mid_cycle();
      check("add_sel", 32'(bus.pcmux_sel), 32'd0);
      check("add_flush", 32'(bus.flush), 32'd0);
      idle(16'h3004);
      mid_cycle();
      check("inval_br_flush", 32'(bus.flush), 32'd0);
      check("model_idx2_unchanged", 32'(m_ctr[2]), 32'd0);

      // Collision: bring idx 2 to 01, then fetch 0x3004 while 0x3024 resolves
      drive(16'h3004, 1'b1, 16'h3004, 4'h0, 1'b1, 1'b0);
      drive(16'h3004, 1'b1, 16'h3024, 4'h0, 1'b1, 1'b0);
      mid_cycle();
      check("collision_pre_pt", 32'(bus.predict_taken), 32'd0);
      idle(16'h3004);
      mid_cycle();
      check("collision_post_pt", 32'(bus.predict_taken), 32'd1);

      // Reset mid-stream with flush high
      drive(16'h3004, 1'b1, 16'h3004, 4'hF, 1'b0, 1'b0);
      idle(16'h3004);
      mid_cycle();
      check("pre_rst_flush", 32'(bus.flush), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_flush", 32'(bus.flush), 32'd0);
      check("async_rst_sel", 32'(bus.pcmux_sel), 32'd0);
      check("async_rst_pt", 32'(bus.predict_taken), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Five branches at 0x0010 (idx 8), two mispredicted
      drive(16'h0010, 1'b1, 16'h0010, 4'h0, 1'b1, 1'b1);
      drive(16'h0010, 1'b1, 16'h0010, 4'h0, 1'b0, 1'b0);
      drive(16'h0010, 1'b1, 16'h0010, 4'h0, 1'b1, 1'b0);
      drive(16'h0010, 1'b1, 16'h0010, 4'h0, 1'b0, 1'b1);
      drive(16'h0010, 1'b1, 16'h0010, 4'h0, 1'b1, 1'b1);
      idle(16'h0010);
      mid_cycle();
      check("model_branches", 32'(m_branches), 32'd5);
      check("model_mispredicts", 32'(m_mispredicts), 32'd2);
      check("model_idx8", 32'(m_ctr[8]), 32'd2);
`ifdef BR_PREDICT_STATS_EN
      check("stat_branches_5", stat_branches, 32'd5);
      check("stat_mispredicts_2", stat_mispredicts, 32'd2);
      rst = 1'b1;
      #1;
      check("stat_branches_rst", stat_branches, 32'd0);
      check("stat_mispredicts_rst", stat_mispredicts, 32'd0);
      @(negedge clk);
      rst = 1'b0;
`endif
      idle(16'h0010);
      idle(16'h0010);
      mid_cycle();

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
